// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and exception controller for a five-stage in-order pipeline
// (IF, ID, EX, MEM, WB).
// - Turns per-stage stall requests into per-register hold enables, letting
//   a bubble into the stage just after the deepest stalled register.
// - Sequences a committed exception/eret through IDLE -> (WAIT) -> FREEZE
//   -> FLUSH -> IDLE. The final step clears the pipeline and redirects the PC.
//
// Optional feature: define PIPE_STALL_WATCHDOG_EN to build a sticky
// consecutive-stall watchdog. Without it, wdog_timeout is tied low.
//
// Ports
//   clk            in   1   single clock, rising edge
//   rst            in   1   asynchronous, active-low reset
//   stall_req_if   in   1   fetch waiting on instruction bus
//   stall_req_id   in   1   decode load-use hazard
//   stall_req_ex   in   1   execute busy (mul/div)
//   stall_req_mem  in   1   memory waiting on data bus
//   exc_valid      in   1   exception/eret committed at MEM
//   exc_target_pc  in  32   redirect address for that exception/eret
//   stall          out  5   hold enables: [0] PC, [1] IF/ID, [2] ID/EX,
//                           [3] EX/MEM, [4] MEM/WB
//   flush          out  1   clear all pipeline registers, load PC
//   flush_pc       out 32   PC load value (meaningful while flush=1)
//   exc_busy       out  1   exception sequence in progress
//   wdog_timeout   out  1   sticky stall-watchdog flag
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        exc_valid,
  input  logic [31:0] exc_target_pc,
  output logic [4:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        exc_busy,
  output logic        wdog_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_FREEZE = 2'd2,
    S_FLUSH  = 2'd3
  } state_e;

  // Reject watchdog limits that a 16-bit counter cannot reach.
  if ((WDOG_LIMIT < 32'd1) || (WDOG_LIMIT > 32'd65535)) begin : g_bad_limit
    $error("pipeline_ctrl: WDOG_LIMIT out of range 1..65535");
  end

  // Deepest requester wins. Every register upstream of it holds, and the
  // register just downstream of it is released so that a bubble enters.
  function automatic logic [4:0] stall_map(input logic req_if, input logic req_id,
                                           input logic req_ex, input logic req_mem);
    logic [4:0] m;
    if (req_mem) begin
      m = 5'b01111;
    end else if (req_ex) begin
      m = 5'b00111;
    end else if (req_id) begin
      m = 5'b00011;
    end else if (req_if) begin
      m = 5'b00001;
    end else begin
      m = 5'b00000;
    end
    return m;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        flush_q;
  logic        busy_q;
  logic [4:0]  stall_s;

  // Next-state logic. The redirect target is captured only when leaving IDLE.
  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      S_IDLE: begin
        if (exc_valid) begin
          flush_pc_d = exc_target_pc;
          if (stall_req_mem) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FREEZE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!stall_req_mem) begin
          state_d = S_FREEZE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FREEZE: state_d = S_FLUSH;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stall decode. This path is combinational from the request inputs so that
  // it keeps tracking requests while reset is held (state_q is IDLE then).
  always_comb begin
    stall_s = 5'b00000;
    case (state_q)
      S_IDLE:   stall_s = stall_map(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
      S_WAIT:   stall_s = stall_map(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
      S_FREEZE: stall_s = 5'b11111;
      S_FLUSH:  stall_s = 5'b00000;
      default:  stall_s = stall_map(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
    endcase
  end

  // State, captured target and registered status outputs.
  // flush and exc_busy are registered copies of the next-state decode, so
  // they line up with state_q without a combinational path from the inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      flush_pc_q <= 32'h0000_0000;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      flush_q    <= (state_d == S_FLUSH);
      busy_q     <= (state_d != S_IDLE);
    end
  end

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIMIT_C = WDOG_LIMIT[15:0];

  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_q, wdog_d;

  // Count consecutive stalled cycles. A free cycle or a flush restarts the
  // count, and the count saturates instead of wrapping.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (flush_q || (stall_s == 5'b00000)) begin
      wdog_cnt_d = 16'd0;
    end else if (wdog_cnt_q != 16'hFFFF) begin
      wdog_cnt_d = wdog_cnt_q + 16'd1;
    end else begin
      wdog_cnt_d = wdog_cnt_q;
    end
    wdog_d = wdog_q | (wdog_cnt_d >= WDOG_LIMIT_C);
  end

  // Watchdog counter and sticky timeout flag. Only reset clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= 16'd0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  assign wdog_timeout = wdog_q;
`else
  assign wdog_timeout = 1'b0;
`endif

  assign stall    = stall_s;
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
  assign exc_busy = busy_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Directed bench for pipeline_ctrl. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_req_if;
  logic        stall_req_id;
  logic        stall_req_ex;
  logic        stall_req_mem;
  logic        exc_valid;
  logic [31:0] exc_target_pc;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        exc_busy;
  logic        wdog_timeout;

  int total;
  int bad;

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam logic WDOG_EXP = 1'b1;
`else
  localparam logic WDOG_EXP = 1'b0;
`endif

  pipeline_ctrl #(.WDOG_LIMIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .exc_valid     (exc_valid),
    .exc_target_pc (exc_target_pc),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .exc_busy      (exc_busy),
    .wdog_timeout  (wdog_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = r;
  endtask

  initial begin
    logic [3:0] req_tab [6];
    logic [4:0] exp_tab [6];
    total = 0;
    bad   = 0;

    // Reset state. Stall must still follow the request inputs while reset is held.
    rst = 1'b0;
    set_req(4'b0000);
    exc_valid     = 1'b0;
    exc_target_pc = 32'h0000_0000;
    #1;
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_flush_pc", flush_pc, 32'h0000_0000);
    check("rst_busy", 32'(exc_busy), 32'd0);
    check("rst_wdog", 32'(wdog_timeout), 32'd0);
    check("rst_stall_none", 32'(stall), 32'd0);
    set_req(4'b0100);
    #1;
    check("rst_stall_ex", 32'(stall), 32'b00111);
    set_req(4'b0000);
    step();
    rst = 1'b1;
    step();

    // Stall mapping. Table bits are {mem, ex, id, if}.
    req_tab[0] = 4'b0001; exp_tab[0] = 5'b00001;
    req_tab[1] = 4'b0010; exp_tab[1] = 5'b00011;
    req_tab[2] = 4'b0100; exp_tab[2] = 5'b00111;
    req_tab[3] = 4'b1000; exp_tab[3] = 5'b01111;
    req_tab[4] = 4'b1010; exp_tab[4] = 5'b01111;
    req_tab[5] = 4'b0101; exp_tab[5] = 5'b00111;
    for (int i = 0; i < 6; i++) begin
      set_req(req_tab[i]);
      #1;
      check($sformatf("map_%0d", i), 32'(stall), 32'(exp_tab[i]));
      check($sformatf("map_flush_%0d", i), 32'(flush), 32'd0);
    end
    set_req(4'b0000);
    step();

    // Exception with no stalls: FREEZE, then FLUSH, then IDLE. A second
    // exception raised during FREEZE must be ignored.
    exc_valid     = 1'b1;
    exc_target_pc = 32'hBFC0_0380;
    #1;
    check("idle_busy", 32'(exc_busy), 32'd0);
    step();
    check("frz_stall", 32'(stall), 32'b11111);
    check("frz_flush", 32'(flush), 32'd0);
    check("frz_busy", 32'(exc_busy), 32'd1);
    exc_target_pc = 32'h8000_0180;
    step();
    exc_valid = 1'b0;
    check("fl_flush", 32'(flush), 32'd1);
    check("fl_pc", flush_pc, 32'hBFC0_0380);
    check("fl_stall", 32'(stall), 32'd0);
    step();
    check("post_flush", 32'(flush), 32'd0);
    check("post_busy", 32'(exc_busy), 32'd0);
    check("post_pc_hold", flush_pc, 32'hBFC0_0380);

    // Exception while MEM is stalled: WAIT for 3 cycles, then FREEZE and FLUSH.
    set_req(4'b1000);
    exc_valid     = 1'b1;
    exc_target_pc = 32'h1234_5678;
    step();
    exc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wait_busy_%0d", i), 32'(exc_busy), 32'd1);
      check($sformatf("wait_flush_%0d", i), 32'(flush), 32'd0);
      check($sformatf("wait_stall_%0d", i), 32'(stall), 32'b01111);
      if (i < 2) step();
    end
    set_req(4'b0000);
    step();
    check("wfrz_stall", 32'(stall), 32'b11111);
    check("wfrz_flush", 32'(flush), 32'd0);
    step();
    check("wfl_flush", 32'(flush), 32'd1);
    check("wfl_pc", flush_pc, 32'h1234_5678);
    step();
    check("wpost_flush", 32'(flush), 32'd0);

    // Reset asserted mid-WAIT abandons the pending exception.
    set_req(4'b1000);
    exc_valid     = 1'b1;
    exc_target_pc = 32'hCAFE_F00D;
    step();
    exc_valid = 1'b0;
    check("rw_busy", 32'(exc_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_busy_rst", 32'(exc_busy), 32'd0);
    check("rw_pc_rst", flush_pc, 32'h0000_0000);
    #2;
    rst = 1'b1;
    set_req(4'b0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rw_noflush_%0d", i), 32'(flush), 32'd0);
      check($sformatf("rw_idle_%0d", i), 32'(exc_busy), 32'd0);
    end

    // Watchdog with limit 8: stall_req_ex held for 8 cycles.
    set_req(4'b0100);
    for (int i = 0; i < 7; i++) step();
    check("wd_pre", 32'(wdog_timeout), 32'd0);
    step();
    check("wd_trip", 32'(wdog_timeout), 32'(WDOG_EXP));
    set_req(4'b0000);
    step();
    step();
    check("wd_sticky", 32'(wdog_timeout), 32'(WDOG_EXP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the directed sequence never reaches its end.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
